// File: rtl/baud_pkg.sv
// Shared types and the baud-code to clocks-per-bit table for the UART baud controller.
package baud_pkg;

    localparam int CNT_W = 19;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    // Codes without a defined rate fall back to the slowest (reset) rate.
    function automatic logic [CNT_W-1:0] baud_period(input logic [3:0] code);
        logic [CNT_W-1:0] p;
        case (code)
            4'd0:    p = 19'd333333;
            4'd1:    p = 19'd83333;
            4'd2:    p = 19'd41667;
            4'd3:    p = 19'd20833;
            4'd4:    p = 19'd10417;
            4'd5:    p = 19'd5208;
            4'd6:    p = 19'd2604;
            4'd7:    p = 19'd1736;
            4'd8:    p = 19'd868;
            4'd9:    p = 19'd434;
            4'd10:   p = 19'd217;
            4'd11:   p = 19'd109;
            default: p = 19'd333333;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/baud_period_lut.sv
// Combinational map from a baud code to its bit period in clocks.
module baud_period_lut
    import baud_pkg::*;
#(
    parameter int W = baud_pkg::CNT_W
) (
    input  logic [3:0]   i_code,
    output logic [W-1:0] o_period
);

    assign o_period = W'(baud_period(i_code));

endmodule

// File: rtl/baud_ctrl.sv
// Baud-rate controller: applies rate changes only while TX and RX are idle and
// generates registered bit-period and mid-bit tick strobes.
module baud_ctrl
    import baud_pkg::*;
#(
    parameter int         CNT_W      = baud_pkg::CNT_W,
    parameter logic [3:0] RESET_BAUD = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       baud_sel_in,
    input  logic             baud_wr,
    input  logic             tx_busy,
    input  logic             rx_busy,
    input  logic             tick_en,
    input  logic             sync_clr,
    output logic [3:0]       baud_active,
    output logic [CNT_W-1:0] period,
    output logic             bit_tick,
    output logic             half_tick,
    output logic             change_pending,
    output logic             change_ack
);

    localparam logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(baud_period(RESET_BAUD));

    state_t           r_state;
    logic [3:0]       r_baud_active;
    logic [3:0]       r_pending_baud;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_counter;
    logic             r_bit_tick;
    logic             r_half_tick;
    logic             r_change_pending;
    logic             r_change_ack;

    logic [CNT_W-1:0] w_lut_period;
    logic [CNT_W-1:0] w_last;
    logic [CNT_W-1:0] w_half_last;
    logic             w_idle;

    baud_period_lut #(.W(CNT_W)) u_lut (
        .i_code   (r_pending_baud),
        .o_period (w_lut_period)
    );

    assign w_last      = r_period - CNT_W'(1);
    assign w_half_last = (r_period >> 1) - CNT_W'(1);
    assign w_idle      = !tx_busy && !rx_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= RUN;
            r_baud_active    <= RESET_BAUD;
            r_pending_baud   <= RESET_BAUD;
            r_period         <= RESET_PERIOD;
            r_counter        <= '0;
            r_bit_tick       <= 1'b0;
            r_half_tick      <= 1'b0;
            r_change_pending <= 1'b0;
            r_change_ack     <= 1'b0;
        end else begin
            r_bit_tick   <= 1'b0;
            r_half_tick  <= 1'b0;
            r_change_ack <= 1'b0;
            case (r_state)
                APPLY: begin
                    // Restart the bit timing at the new rate; no ticks this cycle.
                    r_baud_active <= r_pending_baud;
                    r_period      <= w_lut_period;
                    r_counter     <= '0;
                    r_change_ack  <= 1'b1;
                    if (baud_wr) begin
                        r_pending_baud   <= baud_sel_in;
                        r_state          <= PENDING;
                        r_change_pending <= 1'b1;
                    end else begin
                        r_state          <= RUN;
                        r_change_pending <= 1'b0;
                    end
                end
                default: begin
                    if (sync_clr) begin
                        r_counter <= '0;
                    end else if (tick_en) begin
                        if (r_counter == w_last) begin
                            r_counter  <= '0;
                            r_bit_tick <= 1'b1;
                        end else begin
                            r_counter <= r_counter + CNT_W'(1);
                        end
                        if (r_counter == w_half_last) begin
                            r_half_tick <= 1'b1;
                        end
                    end
                    if (baud_wr) begin
                        r_pending_baud <= baud_sel_in;
                    end
                    // Idle is judged after a same-cycle write, so APPLY uses the newest code.
                    if (r_state == PENDING) begin
                        if (w_idle) begin
                            r_state          <= APPLY;
                            r_change_pending <= 1'b0;
                        end
                    end else if (baud_wr) begin
                        r_state          <= PENDING;
                        r_change_pending <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign baud_active    = r_baud_active;
    assign period         = r_period;
    assign bit_tick       = r_bit_tick;
    assign half_tick      = r_half_tick;
    assign change_pending = r_change_pending;
    assign change_ack     = r_change_ack;

endmodule

// File: tb/tb_baud_ctrl.sv
// Self-checking bench for baud_ctrl: a rate-table reference model predicts every
// cycle's outputs into a queue that an independent monitor drains and compares.
module tb_baud_ctrl;

    localparam int W = 19;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   baud_sel_in = 4'd0;
    logic         baud_wr = 1'b0;
    logic         tx_busy = 1'b0;
    logic         rx_busy = 1'b0;
    logic         tick_en = 1'b0;
    logic         sync_clr = 1'b0;
    logic [3:0]   baud_active;
    logic [W-1:0] period;
    logic         bit_tick;
    logic         half_tick;
    logic         change_pending;
    logic         change_ack;

    always #5 clk = ~clk;

    baud_ctrl #(.CNT_W(W), .RESET_BAUD(4'd0)) dut (
        .clk            (clk),
        .reset          (reset),
        .baud_sel_in    (baud_sel_in),
        .baud_wr        (baud_wr),
        .tx_busy        (tx_busy),
        .rx_busy        (rx_busy),
        .tick_en        (tick_en),
        .sync_clr       (sync_clr),
        .baud_active    (baud_active),
        .period         (period),
        .bit_tick       (bit_tick),
        .half_tick      (half_tick),
        .change_pending (change_pending),
        .change_ack     (change_ack)
    );

    typedef struct packed {
        logic [3:0]   active;
        logic [W-1:0] per;
        logic         bit_t;
        logic         half_t;
        logic         pend;
        logic         ack;
    } obs_t;

    int unsigned ptab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                               868, 434, 217, 109, 333333, 333333, 333333, 333333};

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_ack_seen = 0;

    // Reference model: bit position advances modulo the rate; a request waits for idle.
    int m_active = 0, m_period = 333333, m_phase = 0, m_pend_code = 0;
    int m_st = 0;  // 0 running, 1 waiting for idle, 2 applying this cycle
    logic m_bit, m_half, m_ack, m_cp;

    task automatic model_step(input logic rst, input logic wr, input logic [3:0] sel,
                              input logic tb, input logic rb, input logic te, input logic sc);
        obs_t e;
        m_bit = 1'b0; m_half = 1'b0; m_ack = 1'b0;
        if (rst) begin
            m_active = 0; m_period = int'(ptab[0]); m_phase = 0; m_st = 0;
        end else if (m_st == 2) begin
            m_active = m_pend_code;
            m_period = int'(ptab[m_pend_code]);
            m_phase  = 0;
            m_ack    = 1'b1;
            if (wr) begin m_pend_code = int'(sel); m_st = 1; end
            else m_st = 0;
        end else begin
            if (sc) m_phase = 0;
            else if (te) begin
                m_half  = ((m_phase + 1) == m_period / 2);
                m_phase = (m_phase + 1) % m_period;
                m_bit   = (m_phase == 0);
            end
            if (wr) m_pend_code = int'(sel);
            if (m_st == 1) begin
                if (!tb && !rb) m_st = 2;
            end else if (wr) m_st = 1;
        end
        m_cp = (m_st == 1);
        e.active = 4'(m_active);
        e.per    = W'(m_period);
        e.bit_t  = m_bit;
        e.half_t = m_half;
        e.pend   = m_cp;
        e.ack    = m_ack;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic wr, input logic [3:0] sel,
                        input logic tb, input logic rb, input logic te, input logic sc);
        @(negedge clk);
        reset = rst; baud_wr = wr; baud_sel_in = sel;
        tx_busy = tb; rx_busy = rb; tick_en = te; sync_clr = sc;
        model_step(rst, wr, sel, tb, rb, te, sc);
    endtask

    task automatic run(input int n, input logic tb, input logic rb);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, tb, rb, 1'b1, 1'b0);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        obs_t e;
        obs_t a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {baud_active, period, bit_tick, half_tick, change_pending, change_ack};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle@%0t: got act=%0d per=%0d bit=%b half=%b pend=%b ack=%b, expected act=%0d per=%0d bit=%b half=%b pend=%b ack=%b",
                         $time, a.active, a.per, a.bit_t, a.half_t, a.pend, a.ack,
                         e.active, e.per, e.bit_t, e.half_t, e.pend, e.ack);
            end
            if (change_ack === 1'b1) n_ack_seen++;
        end
    end

    initial begin
        int acks0;
        logic tb_r, rb_r;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(4, 1'b0, 1'b0);
        drain();
        check("reset_active", int'(baud_active), 0);
        check("reset_period", int'(period), 333333);

        // Idle change to code 11, then free-run ticks at 109
        acks0 = n_ack_seen;
        step(1'b0, 1'b1, 4'd11, 1'b0, 1'b0, 1'b1, 1'b0);
        run(250, 1'b0, 1'b0);
        drain();
        check("ack_code11", n_ack_seen - acks0, 1);
        check("period_code11", int'(period), 109);

        // Change held off by tx_busy, ticks stay at the old rate
        run(3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        run(300, 1'b1, 1'b0);
        drain();
        check("pending_while_busy", int'(change_pending), 1);
        run(900, 1'b0, 1'b0);
        drain();
        check("period_code8", int'(period), 868);

        // Last write wins while rx_busy holds the request
        acks0 = n_ack_seen;
        step(1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        run(5, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'd10, 1'b0, 1'b1, 1'b1, 1'b0);
        run(5, 1'b0, 1'b1);
        run(450, 1'b0, 1'b0);
        drain();
        check("single_ack", n_ack_seen - acks0, 1);
        check("active_code10", int'(baud_active), 10);
        check("period_code10", int'(period), 217);

        // Undefined code reports itself but runs at the fallback rate
        step(1'b0, 1'b1, 4'd14, 1'b0, 1'b0, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0);
        drain();
        check("active_code14", int'(baud_active), 14);
        check("period_code14", int'(period), 333333);

        // sync_clr mid-bit and at the last count of a bit
        step(1'b0, 1'b1, 4'd11, 1'b0, 1'b0, 1'b1, 1'b0);
        run(5, 1'b0, 1'b0);
        for (int i = 0; i < 200 && m_phase != 50; i++) run(1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        run(200, 1'b0, 1'b0);
        for (int i = 0; i < 200 && m_phase != 108; i++) run(1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        run(120, 1'b0, 1'b0);

        // Reset while a request is pending discards it
        step(1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        run(4, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        acks0 = n_ack_seen;
        run(20, 1'b0, 1'b0);
        drain();
        check("no_ack_after_reset", n_ack_seen - acks0, 0);
        check("pending_after_reset", int'(change_pending), 0);
        check("active_after_reset", int'(baud_active), 0);

        // Randomized traffic
        tb_r = 1'b0; rb_r = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            logic rst_r, wr_r, te_r, sc_r;
            logic [3:0] sel_r;
            if ($urandom_range(0, 19) == 0) tb_r = ~tb_r;
            if ($urandom_range(0, 19) == 0) rb_r = ~rb_r;
            rst_r = ($urandom_range(0, 799) == 0);
            wr_r  = ($urandom_range(0, 39) == 0);
            sel_r = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(8, 11)) : 4'($urandom_range(0, 15));
            te_r  = ($urandom_range(0, 3) != 0);
            sc_r  = ($urandom_range(0, 99) == 0);
            step(rst_r, wr_r, sel_r, tb_r, rb_r, te_r, sc_r);
        end
        drain();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
